sdft_bin_update: RTL and testbench

- Sliding-DFT update engine that sits directly upstream of the frequency-bin RAM.
- On each accepted input sample it computes delta = new sample − sample leaving the window.
- It then walks every bin k, applying X_k ← (X_k + delta)·W_k, where W_k = e^{+j2πk/N} is read from an external twiddle ROM.
- Each updated bin is written back through the RAM's separate read and write ports.

---
 rtl/sdft_pkg.sv | 21 ++
 rtl/sdft_cmul.sv | 48 ++++
 rtl/sdft_bin_update.sv | 137 +++++++++++++
 tb/tb_sdft_bin_update.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdft_pkg.sv
// Shared widths, FSM encoding and word packing for the sliding-DFT bin updater.
package sdft_pkg;

  localparam int DEF_ADDR_W   = 7;
  localparam int DEF_SAMPLE_W = 8;
  localparam int DEF_BIN_W    = 16;
  localparam int DEF_TW_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Field index within a two-field word: re/cos in the upper half, im/sin in the lower.
  localparam int HI_FIELD = 1;
  localparam int LO_FIELD = 0;

endpackage

// File: rtl/sdft_cmul.sv
// Complex multiply (a + jb)(c + js) with arithmetic scale-down by TW_W-1.
// Operands registered on load_i; outputs are combinational from those registers.
module sdft_cmul #(
  parameter int BIN_W = 16,
  parameter int TW_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [BIN_W:0]   a_i,
  input  logic [BIN_W:0]   b_i,
  input  logic [TW_W-1:0]  c_i,
  input  logic [TW_W-1:0]  s_i,
  output logic [BIN_W-1:0] re_o,
  output logic [BIN_W-1:0] im_o
);
  localparam int PW = BIN_W + TW_W + 2;

  logic signed [BIN_W:0]  a_q, b_q;
  logic signed [TW_W-1:0] c_q, s_q;
  logic signed [PW-1:0]   p_re, p_im, sh_re, sh_im;
  logic                   unused_hi;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      s_q <= '0;
    end else if (load_i) begin
      a_q <= $signed(a_i);
      b_q <= $signed(b_i);
      c_q <= $signed(c_i);
      s_q <= $signed(s_i);
    end
  end

  assign p_re  = PW'(a_q) * PW'(c_q) - PW'(b_q) * PW'(s_q);
  assign p_im  = PW'(a_q) * PW'(s_q) + PW'(b_q) * PW'(c_q);
  assign sh_re = p_re >>> (TW_W - 1);
  assign sh_im = p_im >>> (TW_W - 1);

  // Result wraps to BIN_W bits; the discarded high bits are intentionally dropped.
  assign re_o      = sh_re[BIN_W-1:0];
  assign im_o      = sh_im[BIN_W-1:0];
  assign unused_hi = ^{sh_re[PW-1:BIN_W], sh_im[PW-1:BIN_W]};

endmodule

// File: rtl/sdft_bin_update.sv
// Sliding-DFT engine: per accepted sample, walks all bins X_k <- (X_k + delta) * W_k.
// 3 cycles per bin, done 3N+1 cycles after accept; samples offered while busy are dropped (overrun).
module sdft_bin_update
  import sdft_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int BIN_W    = DEF_BIN_W,
  parameter int TW_W     = DEF_TW_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SAMPLE_W-1:0]  sample,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  output logic                 overrun,
  output logic                 done,
  output logic [ADDR_W-1:0]    r_addr,
  output logic                 r_en,
  input  logic [2*BIN_W-1:0]   r_data,
  output logic [ADDR_W-1:0]    w_addr,
  output logic                 w_en,
  output logic [2*BIN_W-1:0]   w_data,
  output logic [ADDR_W-1:0]    tw_addr,
  output logic                 tw_en,
  input  logic [2*TW_W-1:0]    tw_data
);
  localparam int N      = 1 << ADDR_W;
  localparam int FILL_W = ADDR_W + 1;

  state_e                     state_q, state_d;
  logic [ADDR_W-1:0]          k_q, k_d, ptr_q;
  logic [FILL_W-1:0]          fill_q;
  logic signed [SAMPLE_W:0]   delta_q, delta_d;
  logic [SAMPLE_W-1:0]        ring_q [N];
  logic signed [SAMPLE_W-1:0] oldest;
  logic signed [BIN_W-1:0]    re_rd, im_rd;
  logic [BIN_W:0]             a_d, b_d;
  logic [BIN_W-1:0]           re_new, im_new;
  logic                       accept, last_bin, cmul_load;

  assign sample_ready = (state_q == ST_IDLE) && !reset;
  assign overrun      = sample_valid && !reset && (state_q != ST_IDLE);
  assign accept       = sample_valid && sample_ready;
  assign last_bin     = (k_q == ADDR_W'(N - 1));

  // Until the window has filled, the sample leaving it is implicitly zero.
  assign oldest  = (fill_q == FILL_W'(N)) ? $signed(ring_q[ptr_q]) : '0;
  assign delta_d = $signed({sample[SAMPLE_W-1], sample}) - $signed({oldest[SAMPLE_W-1], oldest});

  assign re_rd = $signed(r_data[HI_FIELD*BIN_W +: BIN_W]);
  assign im_rd = $signed(r_data[LO_FIELD*BIN_W +: BIN_W]);
  assign a_d   = $signed({re_rd[BIN_W-1], re_rd}) + (BIN_W+1)'(delta_q);
  assign b_d   = {im_rd[BIN_W-1], im_rd};

  sdft_cmul #(.BIN_W(BIN_W), .TW_W(TW_W)) u_cmul (
    .clk    (clk),
    .reset  (reset),
    .load_i (cmul_load),
    .a_i    (a_d),
    .b_i    (b_d),
    .c_i    (tw_data[HI_FIELD*TW_W +: TW_W]),
    .s_i    (tw_data[LO_FIELD*TW_W +: TW_W]),
    .re_o   (re_new),
    .im_o   (im_new)
  );

  assign r_addr  = k_q;
  assign tw_addr = k_q;
  assign w_addr  = k_q;
  assign w_data  = w_en ? {re_new, im_new} : '0;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    r_en      = 1'b0;
    tw_en     = 1'b0;
    w_en      = 1'b0;
    done      = 1'b0;
    cmul_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_READ;
          k_d     = '0;
        end
      end
      ST_READ: begin
        r_en    = 1'b1;
        tw_en   = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cmul_load = 1'b1;
        state_d   = ST_WRITE;
      end
      ST_WRITE: begin
        w_en = 1'b1;
        if (last_bin) begin
          state_d = ST_DONE;
        end else begin
          k_d     = k_q + ADDR_W'(1);
          state_d = ST_READ;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k_q     <= '0;
      ptr_q   <= '0;
      fill_q  <= '0;
      delta_q <= '0;
      for (int i = 0; i < N; i++) ring_q[i] <= '0;
    end else begin
      k_q <= k_d;
      if (accept) begin
        delta_q       <= delta_d;
        ring_q[ptr_q] <= sample;
        ptr_q         <= ptr_q + ADDR_W'(1);
        if (fill_q != FILL_W'(N)) fill_q <= fill_q + FILL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sdft_bin_update.sv
// Bench for sdft_bin_update with N=4: behavioural bin RAM / twiddle ROM, write scoreboard.
module tb_sdft_bin_update;
  localparam int AW = 2;
  localparam int N  = 4;
  localparam int SW = 8;
  localparam int BW = 16;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [SW-1:0] sample = '0;
  logic          sample_valid = 1'b0;
  logic          sample_ready, overrun, done, r_en, w_en, tw_en;
  logic [AW-1:0] r_addr, w_addr, tw_addr;
  logic [2*BW-1:0] r_data, w_data;
  logic [2*TW-1:0] tw_data;

  logic [2*BW-1:0] ram [N];
  logic [2*BW-1:0] ram_init [N];
  logic [2*TW-1:0] rom [N];
  logic            ld = 1'b0;

  typedef struct { logic [AW-1:0] addr; logic [2*BW-1:0] dat; } wr_t;
  wr_t q[$];
  wr_t e;

  typedef struct { logic [SW-1:0] s; int re; } vec_t;
  vec_t vt [6];

  int total = 0;
  int bad = 0;
  int wcount = 0;
  int cyc;

  sdft_bin_update #(.ADDR_W(AW), .SAMPLE_W(SW), .BIN_W(BW), .TW_W(TW)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .done         (done),
    .r_addr       (r_addr),
    .r_en         (r_en),
    .r_data       (r_data),
    .w_addr       (w_addr),
    .w_en         (w_en),
    .w_data       (w_data),
    .tw_addr      (tw_addr),
    .tw_en        (tw_en),
    .tw_data      (tw_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < N; i++) ram[i] <= ram_init[i];
    end else if (w_en) begin
      ram[w_addr] <= w_data;
    end
    if (r_en)  r_data  <= ram[r_addr];
    if (tw_en) tw_data <= rom[tw_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] bin(input int re, input int im);
    return {re[15:0], im[15:0]};
  endfunction

  always @(negedge clk) begin
    if (w_en) begin
      wcount++;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious write: addr %0d data %0h with empty scoreboard", w_addr, w_data);
      end else begin
        e = q.pop_front();
        chk("w_addr", 32'(w_addr), 32'(e.addr));
        chk("w_data", w_data, e.dat);
      end
    end
  end

  task automatic push_all(input int re, input int im);
    for (int k = 0; k < N; k++) q.push_back('{AW'(k), bin(re, im)});
  endtask

  task automatic send(input logic [SW-1:0] s);
    int n = 0;
    @(negedge clk);
    while (!sample_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready before send", 32'(sample_ready), 32'd1);
    sample       = s;
    sample_valid = 1'b1;
    @(posedge clk);
    #1 sample_valid = 1'b0;
  endtask

  task automatic wait_done(output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!done && c < 100);
  endtask

  task automatic finish_op(input int exp_cyc, input int c);
    chk("done latency", 32'(c), 32'(exp_cyc));
    chk("ready low in DONE", 32'(sample_ready), 32'd0);
    @(negedge clk);
    chk("done one cycle", 32'(done), 32'd0);
    chk("ready after done", 32'(sample_ready), 32'd1);
  endtask

  task automatic run_sample(input logic [SW-1:0] s);
    int c;
    send(s);
    wait_done(c);
    finish_op(13, c);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      ram_init[i] = '0;
      rom[i]      = 16'h4000;
    end
    vt[0] = '{8'd10,  5};
    vt[1] = '{8'hFA, -1};
    vt[2] = '{8'd100, 49};
    vt[3] = '{8'd3,   26};
    vt[4] = '{8'd7,   11};
    vt[5] = '{8'h80, -56};

    // Reset state, including a sample offered during reset.
    ld = 1'b1;
    sample_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst sample_ready", 32'(sample_ready), 32'd0);
    chk("rst overrun", 32'(overrun), 32'd0);
    chk("rst r_en", 32'(r_en), 32'd0);
    chk("rst w_en", 32'(w_en), 32'd0);
    chk("rst tw_en", 32'(tw_en), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    sample_valid = 1'b0;
    ld    = 1'b0;
    reset = 1'b0;
    #1;
    chk("post-rst sample_ready", 32'(sample_ready), 32'd1);
    chk("post-rst addrs", {26'd0, r_addr, w_addr, tw_addr}, 32'd0);
    chk("post-rst w_data", w_data, 32'd0);

    // Table: all twiddles 0.5, window fills then wraps.
    for (int i = 0; i < 6; i++) begin
      wcount = 0;
      push_all(vt[i].re, 0);
      run_sample(vt[i].s);
      chk("w_en count", 32'(wcount), 32'd4);
    end

    // Overrun during WAIT of bin 2; next delta must still use the pre-overrun oldest.
    push_all(-68, 0);
    send(8'd20);
    repeat (8) @(negedge clk);
    sample       = 8'd55;
    sample_valid = 1'b1;
    #1;
    chk("overrun pulse", 32'(overrun), 32'd1);
    chk("ready low busy", 32'(sample_ready), 32'd0);
    @(posedge clk);
    #1 sample_valid = 1'b0;
    @(negedge clk);
    chk("overrun cleared", 32'(overrun), 32'd0);
    wait_done(cyc);
    finish_op(4, cyc);
    push_all(-36, 0);
    run_sample(8'd0);

    // Reset during WRITE of bin 1.
    q.push_back('{AW'(0), bin(3, 0)});
    q.push_back('{AW'(1), bin(3, 0)});
    send(8'd50);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(w_en && w_addr == AW'(1)) && cyc < 50);
    chk("reached WRITE bin1", 32'(cyc), 32'd6);
    reset = 1'b1;
    @(negedge clk);
    chk("mid-rst w_en", 32'(w_en), 32'd0);
    chk("mid-rst r_en", 32'(r_en), 32'd0);
    chk("mid-rst tw_en", 32'(tw_en), 32'd0);
    chk("mid-rst ready", 32'(sample_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("ready after mid-rst", 32'(sample_ready), 32'd1);
    chk("writes before reset", 32'(q.size()), 32'd0);

    // Rotation by j on bin 1, then a negative sample exercising the cross terms.
    ram_init[1] = bin(100, 0);
    rom[1]      = 16'h007F;
    @(negedge clk);
    ld = 1'b1;
    @(posedge clk);
    #1 ld = 1'b0;
    q.push_back('{AW'(0), bin(0, 0)});
    q.push_back('{AW'(1), bin(0, 99)});
    q.push_back('{AW'(2), bin(0, 0)});
    q.push_back('{AW'(3), bin(0, 0)});
    run_sample(8'd0);
    q.push_back('{AW'(0), bin(-10, 0)});
    q.push_back('{AW'(1), bin(-99, -20)});
    q.push_back('{AW'(2), bin(-10, 0)});
    q.push_back('{AW'(3), bin(-10, 0)});
    run_sample(8'hEC);

    repeat (5) @(negedge clk);
    chk("scoreboard drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
